// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports,
// optional write-to-read bypass and a per-register pending scoreboard with a live count.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           i_rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   i_raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   o_rdata,
  output logic [NUM_RD-1:0]              o_rbusy,
  input  logic [1:0]                     i_wen,
  input  logic [2*ADDR_WIDTH-1:0]        i_waddr,
  input  logic [2*DATA_WIDTH-1:0]        i_wdata,
  input  logic                           i_iss_en,
  input  logic [ADDR_WIDTH-1:0]          i_iss_addr,
  output logic [ADDR_WIDTH:0]            o_npend
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      pend_q, pend_d;
  logic [ADDR_WIDTH:0]   npend_q, npend_d;
  logic [DEPTH-1:0]      wr_hit0, wr_hit1, iss_hit;
  logic                  inc;
  logic [1:0]            dec;

  logic [ADDR_WIDTH-1:0] waddr0, waddr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;

  assign waddr0 = i_waddr[0 +: ADDR_WIDTH];
  assign waddr1 = i_waddr[ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata0 = i_wdata[0 +: DATA_WIDTH];
  assign wdata1 = i_wdata[DATA_WIDTH +: DATA_WIDTH];

  // Register 0 is excluded here so it can never be written or marked pending.
  always_comb begin
    wr_hit0 = '0;
    wr_hit1 = '0;
    iss_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (!(ZERO_REG != 0 && r == 0)) begin
        wr_hit0[r] = i_wen[0] && (waddr0 == ADDR_WIDTH'(r));
        wr_hit1[r] = i_wen[1] && (waddr1 == ADDR_WIDTH'(r));
        iss_hit[r] = i_iss_en && (i_iss_addr == ADDR_WIDTH'(r));
      end
    end
  end

  // A new issue outranks a writeback to the same register.
  always_comb begin
    pend_d = pend_q;
    inc    = 1'b0;
    dec    = 2'd0;
    for (int r = 0; r < DEPTH; r++) begin
      if (iss_hit[r]) begin
        pend_d[r] = 1'b1;
        if (!pend_q[r]) inc = 1'b1;
      end else if (wr_hit0[r] || wr_hit1[r]) begin
        pend_d[r] = 1'b0;
        if (pend_q[r]) dec = dec + 2'd1;
      end
    end
    npend_d = npend_q + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      pend_q  <= '0;
      npend_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit1[r])      mem_q[r] <= wdata1;
        else if (wr_hit0[r]) mem_q[r] <= wdata0;
      end
      pend_q  <= pend_d;
      npend_q <= npend_d;
    end
  end

  assign o_npend = npend_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  zero, byp0, byp1, iss_same;

    assign ra       = i_raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign zero     = (ZERO_REG != 0) && (ra == '0);
    assign byp0     = (BYPASS != 0) && !i_rst && i_wen[0] && (waddr0 == ra);
    assign byp1     = (BYPASS != 0) && !i_rst && i_wen[1] && (waddr1 == ra);
    assign iss_same = i_iss_en && (i_iss_addr == ra);

    assign o_rdata[k*DATA_WIDTH +: DATA_WIDTH] = zero ? '0     :
                                                 byp1 ? wdata1 :
                                                 byp0 ? wdata0 : mem_q[ra];
    // A bypassed writeback satisfies the consumer unless a new producer claims it now.
    assign o_rbusy[k] = !i_rst && pend_q[ra] && !((byp0 || byp1) && !iss_same);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp: default, no-bypass and wide 4-read-port instances.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raddr;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        iss_en;
  logic [4:0]  iss_addr;

  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic [5:0]  npend_b, npend_n;

  logic [15:0]  w_raddr;
  logic [255:0] w_rdata;
  logic [3:0]   w_rbusy;
  logic [1:0]   w_wen;
  logic [7:0]   w_waddr;
  logic [127:0] w_wdata;
  logic         w_iss_en;
  logic [3:0]   w_iss_addr;
  logic [4:0]   w_npend;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_mp u_byp (
    .clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_b), .o_rbusy(rbusy_b),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_iss_en(iss_en),
    .i_iss_addr(iss_addr), .o_npend(npend_b)
  );

  regfile_mp #(.BYPASS(0)) u_nbyp (
    .clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_n), .o_rbusy(rbusy_n),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_iss_en(iss_en),
    .i_iss_addr(iss_addr), .o_npend(npend_n)
  );

  regfile_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_RD(4)) u_wide (
    .clk(clk), .i_rst(rst), .i_raddr(w_raddr), .o_rdata(w_rdata), .o_rbusy(w_rbusy),
    .i_wen(w_wen), .i_waddr(w_waddr), .i_wdata(w_wdata), .i_iss_en(w_iss_en),
    .i_iss_addr(w_iss_addr), .o_npend(w_npend)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic [5:0]  en;
    logic [31:0] n0, n1;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic [1:0] we, logic [4:0] a0, logic [31:0] d0,
                              logic [4:0] a1, logic [31:0] d1, logic is, logic [4:0] ia,
                              logic [4:0] r0, logic [4:0] r1, logic [31:0] e0, logic [31:0] e1,
                              logic [1:0] eb, logic [5:0] en, logic [31:0] n0, logic [31:0] n1);
    vec_t v;
    v.rst = r;  v.wen = we; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
    v.iss = is; v.ia = ia;  v.ra0 = r0; v.ra1 = r1; v.e0 = e0;  v.e1 = e1;
    v.eb = eb;  v.en = en;  v.n0 = n0;  v.n1 = n1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] wval(input int i);
    logic [63:0] b;
    b = 64'h1111_1111_1111_1111;
    return b * 64'(i);
  endfunction

  initial begin
    rst = 1'b1; raddr = '0; wen = '0; waddr = '0; wdata = '0; iss_en = 1'b0; iss_addr = '0;
    w_raddr = '0; w_wen = '0; w_waddr = '0; w_wdata = '0; w_iss_en = 1'b0; w_iss_addr = '0;

    //            rst wen  wa0  wd0           wa1  wd1           iss ia  ra0 ra1 e0            e1            eb     np n0            n1
    vq.push_back(mk(0, 2'b11, 5, 32'hDEADBEEF, 9, 32'h12345678, 0, 0,  9,  5, 32'h12345678, 32'hDEADBEEF, 2'b00, 0, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0,  9,  5, 32'h12345678, 32'hDEADBEEF, 2'b00, 0, 32'h12345678, 32'hDEADBEEF));
    vq.push_back(mk(0, 2'b11, 7, 32'h11,       7, 32'h22,       0, 0,  7,  7, 32'h22,       32'h22,       2'b00, 0, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0,  7,  7, 32'h22,       32'h22,       2'b00, 0, 32'h22,       32'h22));
    vq.push_back(mk(0, 2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1, 0,  0,  0, 32'h0,        32'h0,        2'b00, 0, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            1, 3,  3,  0, 32'h0,        32'h0,        2'b00, 0, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            1, 4,  3,  4, 32'h0,        32'h0,        2'b01, 1, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b01, 3, 32'hAAAA,     0, 0,            1, 3,  3,  4, 32'hAAAA,     32'h0,        2'b11, 2, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b10, 0, 0,            4, 32'hBBBB,     0, 0,  3,  4, 32'hAAAA,     32'hBBBB,     2'b01, 2, 32'hAAAA,     32'h0));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0,  3,  4, 32'hAAAA,     32'hBBBB,     2'b01, 1, 32'hAAAA,     32'hBBBB));
    vq.push_back(mk(0, 2'b11, 5, 32'h55,       3, 32'h33,       0, 0,  5,  3, 32'h55,       32'h33,       2'b00, 1, 32'hDEADBEEF, 32'hAAAA));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            1, 6,  5,  3, 32'h55,       32'h33,       2'b00, 0, 32'h55,       32'h33));
    vq.push_back(mk(1, 2'b01, 9, 32'hFF,       0, 0,            1, 9,  9,  6, 32'h12345678, 32'h0,        2'b00, 1, 32'h12345678, 32'h0));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0,  9,  6, 32'h0,        32'h0,        2'b00, 0, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0,  5,  7, 32'h0,        32'h0,        2'b00, 0, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            1, 1,  1,  2, 32'h0,        32'h0,        2'b00, 0, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            1, 2,  1,  2, 32'h0,        32'h0,        2'b01, 1, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            1, 1,  1,  2, 32'h0,        32'h0,        2'b11, 2, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b11, 1, 32'h101,      2, 32'h202,      0, 0,  1,  2, 32'h101,      32'h202,      2'b00, 2, 32'h0,        32'h0));
    vq.push_back(mk(0, 2'b00, 0, 0,            0, 0,            0, 0,  1,  2, 32'h101,      32'h202,      2'b00, 0, 32'h101,      32'h202));

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst      = vq[i].rst;
      wen      = vq[i].wen;
      waddr    = {vq[i].wa1, vq[i].wa0};
      wdata    = {vq[i].wd1, vq[i].wd0};
      iss_en   = vq[i].iss;
      iss_addr = vq[i].ia;
      raddr    = {vq[i].ra1, vq[i].ra0};
      #1;
      check($sformatf("v%0d rdata0", i),   64'(rdata_b[31:0]),  64'(vq[i].e0));
      check($sformatf("v%0d rdata1", i),   64'(rdata_b[63:32]), 64'(vq[i].e1));
      check($sformatf("v%0d rbusy", i),    64'(rbusy_b),        64'(vq[i].eb));
      check($sformatf("v%0d npend", i),    64'(npend_b),        64'(vq[i].en));
      check($sformatf("v%0d nb rdata0", i), 64'(rdata_n[31:0]),  64'(vq[i].n0));
      check($sformatf("v%0d nb rdata1", i), 64'(rdata_n[63:32]), 64'(vq[i].n1));
    end

    @(negedge clk);
    rst = 1'b0; wen = '0; iss_en = 1'b0;

    // Wide instance: fill regs 1..15 through port 0, port 1 tries to write reg 0.
    for (int i = 1; i < 16; i++) begin
      w_wen   = (i == 1) ? 2'b11 : 2'b01;
      w_waddr = {4'd0, 4'(i)};
      w_wdata = {64'hFFFF_FFFF_FFFF_FFFF, wval(i)};
      @(negedge clk);
    end
    w_wen   = '0;
    w_raddr = {4'd0, 4'd15, 4'd8, 4'd1};
    #1;
    check("wide slot0", w_rdata[63:0],    wval(1));
    check("wide slot1", w_rdata[127:64],  wval(8));
    check("wide slot2", w_rdata[191:128], wval(15));
    check("wide slot3", w_rdata[255:192], 64'h0);
    check("wide rbusy", 64'(w_rbusy), 64'h0);
    check("wide npend", 64'(w_npend), 64'h0);

    w_raddr = {4'd5, 4'd4, 4'd3, 4'd2};
    w_iss_en = 1'b1; w_iss_addr = 4'd3;
    #1;
    check("wide slot0 b", w_rdata[63:0],    wval(2));
    check("wide slot3 b", w_rdata[255:192], wval(5));
    @(negedge clk);
    w_iss_en = 1'b0;
    #1;
    check("wide rbusy iss", 64'(w_rbusy), 64'h2);
    check("wide npend iss", 64'(w_npend), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, 2-read CPU regfile.
- Generalised in data width, register count, read-port count and write-port count (2).
- Adds optional write-to-read bypass and a per-register pending (scoreboard) bit set at issue and cleared at writeback.
- Sits in ID/WB of the pipelined CPU. Lets the hazard unit stall on pending sources and supports dual writeback (ALU + load).

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = read sees same-cycle write data; 0 = read sees stored value only
ZERO_REG, 1, 1 = register 0 hardwired to zero, writes and issues to it ignored

Ports:
clk  in  1  clock, all state updates on rising edge
i_rst  in  1  reset; synchronous, active-high
i_raddr  in  NUM_RD*ADDR_WIDTH  packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
o_rdata  out  NUM_RD*DATA_WIDTH  packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
o_rbusy  out  NUM_RD  pending bit of each read address
i_wen  in  2  write enables, port 0 and port 1
i_waddr  in  2*ADDR_WIDTH  packed write addresses
i_wdata  in  2*DATA_WIDTH  packed write data
i_iss_en  in  1  mark destination pending
i_iss_addr  in  ADDR_WIDTH  destination being issued
o_npend  out  ADDR_WIDTH+1  registered count of pending registers

Behaviour:
- Reset (i_rst high at an edge):
  - All registers cleared to 0; all pending bits cleared; o_npend = 0 on the following cycle.
  - Writes and issues in a reset cycle are ignored.
  - While i_rst is high, bypass is suppressed and o_rbusy = 0.
- Write:
  - At the edge, port p with i_wen[p]=1 stores its data at its address.
  - Both ports to the same address: port 1 wins.
  - Address 0 with ZERO_REG=1: no effect.
- Read (combinational, 0-cycle latency):
  - Address 0 with ZERO_REG=1 returns 0.
  - Else, BYPASS=1 and a same-cycle enabled write matches the address: return that write data (port 1 over port 0).
  - Else return the stored value.
  - BYPASS=0: a same-cycle write becomes visible the next cycle.
- Pending bits:
  - Set at the edge by i_iss_en for i_iss_addr.
  - Cleared at the edge by any enabled write to that address.
  - Issue and write to the same address in one cycle: bit ends set (new producer wins).
  - Address 0 with ZERO_REG=1: never pending.
- o_rbusy[k]:
  - Equals the pending bit of read port k's address.
  - With BYPASS=1, forced 0 when a same-cycle write hits that address, unless that address is also being issued.
- o_npend:
  - Registered; equals the popcount of pending bits after the edge.
  - Updated incrementally: +1 on a set of a clear bit, -1 per clear of a set bit.
  - Never wraps; the maximum is 2**ADDR_WIDTH (or 2**ADDR_WIDTH-1 with ZERO_REG=1).
- Writing an already non-pending register leaves its bit and o_npend unchanged.

Test Plan:
- Reset with all regs previously nonzero -> read any addr returns 0x00000000, o_rbusy=0, o_npend=0 the next cycle.
- Write port 0 addr 5 = 0xDEADBEEF, BYPASS=1, read port 1 addr 5 in the same cycle -> 0xDEADBEEF that cycle; BYPASS=0 -> old value 0, then 0xDEADBEEF the next cycle.
- Both write ports to addr 7, data 0x11 / 0x22 -> stored and bypassed value 0x22.
- Write addr 0 = 0xFFFFFFFF and issue addr 0 -> read addr 0 returns 0, o_npend stays 0.
- Scoreboard sequence:
  - Issue addr 3 -> next cycle o_rbusy=1 for addr 3, o_npend=1.
  - Issue addr 4 -> o_npend=2.
  - Write addr 3 while issuing addr 3 -> addr 3 stays busy, o_npend=2.
  - Write addr 4 -> o_npend=1.
- NUM_RD=4, DATA_WIDTH=64, ADDR_WIDTH=4: write distinct values to regs 1..15, read 4 ports with addrs 1,8,15,0 -> correct values at the packed slices, slot 3 = 0.
